light_bar_sequencer: RTL and testbench
======================================

// Module: light_bar_sequencer
// PURPOSE
//   Parametrised sequencer for the light bar: steps a one-hot enable across NUM_LIGHTS outputs
//   at a fixed dwell rate set by an internal prescaler.
//   Sits between the board clock, the on/off switch and the jump button, and drives the light enables and the state display.
//   Adds reverse, ping-pong and hold modes to plain forward cycling.
//   Fully synchronous: no derived or gated clocks.
// PARAMETERS
//   NUM_LIGHTS  4          number of light channels, 1..16
//   TICK_DIV    500000000  clock cycles per step, >=2 (use 4 in simulation)
//   IDX_W       4          width of state_idx; must satisfy 2**IDX_W >= NUM_LIGHTS
// PORTS
//   clock      in   1           system clock, all state on rising edge
//   reset      in   1           asynchronous active-low reset
//   switch     in   1           run enable; 0 = bar off, prescaler frozen
//   jump       in   1           jump button, active-high; synchronised to clock internally
//   mode       in   2           00 fwd-wrap, 01 rev-wrap, 10 ping-pong, 11 hold
//   enables    out  NUM_LIGHTS  one-hot light enable, bit i = light i
//   state_idx  out  IDX_W       current light index, zero-extended
//   step       out  1           1-cycle pulse on each index update (tick or jump)
// BEHAVIOUR
//   Reset (reset=0, async):
//     idx=0, dir=up, prescaler cnt=0, step=0, jump sync/edge regs=0.
//     Outputs follow these values immediately.
//   Input sync: jump passes through a 2-flop synchroniser, then a rising-edge detect -> jump_p.
//     Latency from the jump edge to jump_p is 2-3 cycles.
//     Holding jump high gives exactly one jump_p.
//   Prescaler:
//     While switch=1, cnt increments each cycle.
//     At cnt==TICK_DIV-1, tick=1 for one cycle and cnt<=0.
//     While switch=0, cnt holds its value and tick=0.
//   Index update, priority high->low, evaluated at each clock edge:
//     1. jump_p & switch: idx<=NUM_LIGHTS-1, dir<=down, cnt<=0, step=1. Jump overrides a coincident tick.
//     2. tick & mode==00: idx<=(idx==NUM_LIGHTS-1)?0:idx+1.
//     3. tick & mode==01: idx<=(idx==0)?NUM_LIGHTS-1:idx-1.
//     4. tick & mode==10 (ping-pong):
//          dir=up   & idx<NUM_LIGHTS-1 -> idx+1
//          dir=up   & idx==NUM_LIGHTS-1 -> dir<=down, idx-1
//          dir=down & idx>0 -> idx-1
//          dir=down & idx==0 -> dir<=up, idx+1
//          Ends are visited once per bounce, not repeated.
//     5. tick & mode==11: idx unchanged, step=0. The prescaler keeps running.
//   step is asserted the cycle after any idx update from cases 1-4 (registered).
//   jump_p while switch=0 is ignored.
//   Mode is sampled only at a tick; changing mode never moves idx by itself.
//   dir is kept across mode changes and is used only in ping-pong.
//   NUM_LIGHTS==1: idx stays 0 in all modes; ticks still produce step in modes 00-10.
//   Ping-pong with NUM_LIGHTS==2 alternates 0,1,0,1.
//   enables = switch ? (1<<idx) : 0. This path is combinational from the registered idx, so switch=0 blanks the bar immediately.
//   state_idx = idx regardless of switch.
//   Switch toggling preserves idx, dir and cnt (pause/resume).
//   Reset asserted mid-count or mid-bounce returns everything to the reset values; no partial step pulse.
//   Out-of-range idx is unreachable.
// TESTING (NUM_LIGHTS=4, TICK_DIV=4 unless stated)
//   1. Reset release, switch=1, mode=00 -> step every 4 clocks; idx 0,1,2,3,0; enables 0001,0010,0100,1000,0001.
//   2. mode=10 from idx 0 -> idx 1,2,3,2,1,0,1; dir flips at 3 and 0; no repeated end value.
//   3. mode=01 -> idx 0,3,2,1,0; then mode=11 -> idx frozen for 5 ticks, step stays 0.
//   4. jump pulse at idx 1 on the same cycle as a tick -> idx=3, dir=down, cnt=0.
//      The next step comes 4 clocks later. Holding jump high for 20 clocks yields one jump.
//   5. switch=0 at cnt=2, idx=2 for 10 clocks -> enables=0000, state_idx=2, cnt held.
//      switch=1 -> the next step comes after 2 clocks.
//   6. reset asserted mid-ping-pong (idx=2, dir=down) -> idx=0, dir=up, step=0 asynchronously.
//      NUM_LIGHTS=1 build: idx always 0.

Source files
------------

// File: rtl/light_bar_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_bar_sequencer: prescaled one-hot light stepper with fwd/rev/ping-pong/hold |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module light_bar_sequencer #(
  parameter int NUM_LIGHTS = 4,
  parameter int TICK_DIV   = 500000000,
  parameter int IDX_W      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  switch,
  input  logic                  jump,
  input  logic [1:0]            mode,
  output logic [NUM_LIGHTS-1:0] enables,
  output logic [IDX_W-1:0]      state_idx,
  output logic                  step
);

  localparam int                  CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_LIGHTS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [NUM_LIGHTS-1:0] LIGHT0  = NUM_LIGHTS'(1);

  localparam logic [1:0] MODE_FWD  = 2'b00;
  localparam logic [1:0] MODE_REV  = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [0:0] DIR_UP    = 1'b0;
  localparam logic [0:0] DIR_DOWN  = 1'b1;

  logic [IDX_W-1:0] idx, idx_nxt;
  logic [0:0]       dir, dir_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sync1, sync2, sync3;
  logic             jump_p, tick;

  assign jump_p = sync2 & ~sync3;
  assign tick   = switch & (cnt == CNT_LAST);

  always_comb begin
    idx_nxt = idx;
    dir_nxt = dir;
    case (mode)
      MODE_FWD: idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
      MODE_REV: idx_nxt = (idx == '0) ? IDX_LAST : idx - IDX_ONE;
      MODE_PING: begin
        if (dir == DIR_UP) begin
          if (idx < IDX_LAST) begin
            idx_nxt = idx + IDX_ONE;
          end else begin
            dir_nxt = DIR_DOWN;
            idx_nxt = idx - IDX_ONE;
          end
        end else begin
          if (idx > '0) begin
            idx_nxt = idx - IDX_ONE;
          end else begin
            dir_nxt = DIR_UP;
            idx_nxt = idx + IDX_ONE;
          end
        end
      end
      default: ;
    endcase
    // A single light has nowhere to go; keep the bounce arithmetic from wrapping.
    if (NUM_LIGHTS == 1) idx_nxt = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      dir   <= DIR_UP;
      cnt   <= '0;
      step  <= 1'b0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= jump;
      sync2 <= sync1;
      sync3 <= sync2;
      step  <= 1'b0;
      if (jump_p && switch) begin
        idx  <= IDX_LAST;
        dir  <= DIR_DOWN;
        cnt  <= '0;
        step <= 1'b1;
      end else if (switch) begin
        cnt <= tick ? '0 : cnt + CNT_ONE;
        if (tick && (mode != MODE_HOLD)) begin
          idx  <= idx_nxt;
          dir  <= dir_nxt;
          step <= 1'b1;
        end
      end
    end
  end

  assign enables   = switch ? (LIGHT0 << idx) : '0;
  assign state_idx = idx;

endmodule
`default_nettype wire

// File: tb/tb_light_bar_sequencer.sv
`default_nettype none
// Bench for light_bar_sequencer: directed and random stimulus against a behavioural model.
module tb_light_bar_sequencer;

  localparam int N  = 4;
  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       switch = 1'b0;
  logic       jump = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [N-1:0] enables;
  logic [3:0]   state_idx;
  logic         step;
  logic [0:0]   enables1;
  logic [0:0]   state_idx1;
  logic         step1;

  light_bar_sequencer #(.NUM_LIGHTS(N), .TICK_DIV(TD), .IDX_W(4)) dut (
    .clock(clock), .reset(reset), .switch(switch), .jump(jump), .mode(mode),
    .enables(enables), .state_idx(state_idx), .step(step)
  );

  light_bar_sequencer #(.NUM_LIGHTS(1), .TICK_DIV(TD), .IDX_W(1)) dut1 (
    .clock(clock), .reset(reset), .switch(switch), .jump(jump), .mode(mode),
    .enables(enables1), .state_idx(state_idx1), .step(step1)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: light position, direction (1 = up), cycles since last step, jump history
  int m_idx;
  int m_cnt;
  bit m_up;
  bit m_step;
  bit hist [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_cnt  = 0;
    m_up   = 1'b1;
    m_step = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit jp, tk;
    // jump seen at edge k-2 but not at k-3 -> a fresh press reaches the logic now
    jp = hist[1] && !hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = jump;
    tk = switch && (m_cnt == TD - 1);
    m_step = 1'b0;
    if (jp && switch) begin
      m_idx  = N - 1;
      m_up   = 1'b0;
      m_cnt  = 0;
      m_step = 1'b1;
    end else if (switch) begin
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) begin
        case (mode)
          2'b00: m_idx = (m_idx + 1) % N;
          2'b01: m_idx = (m_idx + N - 1) % N;
          2'b10: begin
            if (m_up && m_idx == N - 1) m_up = 1'b0;
            else if (!m_up && m_idx == 0) m_up = 1'b1;
            m_idx = m_up ? m_idx + 1 : m_idx - 1;
          end
          default: ;
        endcase
        m_step = (mode != 2'b11);
      end
    end
  endtask

  task automatic check_outputs();
    check("state_idx", 32'(state_idx), 32'(m_idx));
    check("enables", 32'(enables), switch ? (32'd1 << m_idx) : 32'd0);
    check("step", 32'(step), 32'(m_step));
    check("n1_state_idx", 32'(state_idx1), 32'd0);
    check("n1_enables", 32'(enables1), 32'(switch));
    check("n1_step", 32'(step1), 32'(m_step));
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_edge();
    else model_reset();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();
    cycle();

    // Forward wrap from reset: first step after exactly TD clocks
    reset = 1'b1; switch = 1'b1; mode = 2'b00;
    run(3);
    check("idle_before_tick", 32'(step), 32'd0);
    run(1);
    check("first_step", 32'(step), 32'd1);
    check("first_idx", 32'(state_idx), 32'd1);
    run(16);

    mode = 2'b10; run(40);
    mode = 2'b01; run(20);
    mode = 2'b11; run(24);

    // Long jump press must yield a single jump
    mode = 2'b00; jump = 1'b1; run(20);
    jump = 1'b0; run(9);

    // Pause blanks immediately and resumes where it left off
    switch = 1'b0; #1;
    check("blank_immediate", 32'(enables), 32'd0);
    run(10);
    switch = 1'b1; run(12);

    // Asynchronous reset mid ping-pong
    mode = 2'b10; run(13);
    #2 reset = 1'b0; #1;
    check("async_rst_idx", 32'(state_idx), 32'd0);
    check("async_rst_step", 32'(step), 32'd0);
    model_reset();
    check_outputs();
    run(2);
    reset = 1'b1;
    run(10);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) mode = 2'($urandom_range(3, 0));
      if (switch) begin
        if ($urandom_range(63, 0) == 0) switch = 1'b0;
      end else if ($urandom_range(7, 0) == 0) begin
        switch = 1'b1;
      end
      if ($urandom_range(23, 0) == 0) jump = ~jump;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
